// File: rtl/poly_voice_bank_if.sv
// Note-event, step-ROM, sine-lookup and mixed-sample signals of the polyphonic voice bank.
// master = event source and lookup tables, slave = voice bank.
interface poly_voice_bank_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int OUT_W      = 16
);
  logic                  note_valid;
  logic                  note_ready;
  logic                  note_on;
  logic [6:0]            note_num;
  logic [6:0]            step_note;
  logic [PHASE_W-1:0]    step_val;
  logic                  sample_en;
  logic [15:0]           sine_phase;
  logic [OUT_W-1:0]      sine_val;
  logic [OUT_W-1:0]      sample_out;
  logic                  sample_valid;
  logic [NUM_VOICES-1:0] active_mask;
  logic                  alloc_drop;
  logic                  overrun;

  modport master (
    output note_valid, note_on, note_num, step_val, sample_en, sine_val,
    input  note_ready, step_note, sine_phase, sample_out, sample_valid,
           active_mask, alloc_drop, overrun
  );

  modport slave (
    input  note_valid, note_on, note_num, step_val, sample_en, sine_val,
    output note_ready, step_note, sine_phase, sample_out, sample_valid,
           active_mask, alloc_drop, overrun
  );
endinterface

// File: rtl/poly_voice_bank.sv
// Polyphonic phase-accumulator bank: allocates voices from note events, renders them through one shared sine lookup.
// sample_en -> sample_valid in NUM_VOICES+2 cycles; notes are held off (note_ready=0) while a sample renders.
module poly_voice_bank #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int OUT_W      = 16
) (
  input logic              clk,
  input logic              reset_n,
  poly_voice_bank_if.slave vb
);
  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = OUT_W + VIDX_W;

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_RENDER, S_DRAIN, S_EMIT} state_t;

  state_t                    r_state, w_state_nxt;
  logic [PHASE_W-1:0]        r_phase [NUM_VOICES];
  logic [PHASE_W-1:0]        r_step  [NUM_VOICES];
  logic [6:0]                r_note  [NUM_VOICES];
  logic [NUM_VOICES-1:0]     r_active;
  logic [VIDX_W-1:0]         r_sel;
  logic                      r_hit;
  logic [VIDX_W-1:0]         r_ridx;
  logic                      r_prev_act;
  logic signed [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]          r_sample_out;
  logic [6:0]                r_step_note;
  logic [15:0]               r_sine_phase;

  logic                      w_note_ready, w_on_hs, w_off_hs, w_start;
  logic                      w_match, w_free;
  logic [VIDX_W-1:0]         w_match_idx, w_free_idx;
  logic [NUM_VOICES-1:0]     w_off_mask;
  logic [PHASE_W-1:0]        w_phase_nxt;
  logic                      w_cur_act, w_do_acc;
  logic [15:0]               w_sine_phase;
  logic signed [ACC_W-1:0]   w_add, w_acc_sum;
  logic [OUT_W-1:0]          w_mix;

  // A coincident sample strobe blocks the note so the render starts on time.
  assign w_note_ready = (r_state == S_IDLE) && !vb.sample_en;
  assign w_on_hs      = vb.note_valid && w_note_ready && vb.note_on;
  assign w_off_hs     = vb.note_valid && w_note_ready && !vb.note_on;
  assign w_start      = (r_state == S_IDLE) && vb.sample_en;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    w_off_mask  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (r_active[v] && (r_note[v] == vb.note_num)) begin
        w_match       = 1'b1;
        w_match_idx   = VIDX_W'(v);
        w_off_mask[v] = 1'b1;
      end
      if (!r_active[v]) begin
        w_free     = 1'b1;
        w_free_idx = VIDX_W'(v);
      end
    end
  end

  assign w_phase_nxt  = r_phase[r_ridx] + r_step[r_ridx];
  assign w_cur_act    = r_active[r_ridx];
  assign w_sine_phase = w_cur_act ? w_phase_nxt[PHASE_W-1 -: 16] : 16'h0000;
  // sine_val lags sine_phase by one cycle, so it belongs to the previously rendered voice.
  assign w_add        = r_prev_act ? {{VIDX_W{vb.sine_val[OUT_W-1]}}, vb.sine_val} : '0;
  assign w_acc_sum    = r_acc + w_add;
  assign w_do_acc     = ((r_state == S_RENDER) && (r_ridx != '0)) || (r_state == S_DRAIN);
  assign w_mix        = OUT_W'(w_acc_sum >>> VIDX_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (vb.sample_en) w_state_nxt = S_RENDER;
                else if (w_on_hs) w_state_nxt = S_STEP;
      S_STEP:   w_state_nxt = S_IDLE;
      S_RENDER: if (r_ridx == VIDX_W'(NUM_VOICES - 1)) w_state_nxt = S_DRAIN;
      S_DRAIN:  w_state_nxt = S_EMIT;
      S_EMIT:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    vb.note_ready   = w_note_ready;
    vb.alloc_drop   = (r_state == S_STEP) && !r_hit;
    vb.overrun      = vb.sample_en && (r_state != S_IDLE);
    vb.sample_valid = (r_state == S_EMIT);
    vb.sample_out   = r_sample_out;
    vb.active_mask  = r_active;
    vb.sine_phase   = (r_state == S_RENDER) ? w_sine_phase : r_sine_phase;
    vb.step_note    = w_on_hs ? vb.note_num : r_step_note;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_phase[v] <= '0;
        r_step[v]  <= '0;
        r_note[v]  <= '0;
      end
      r_active     <= '0;
      r_sel        <= '0;
      r_hit        <= 1'b0;
      r_ridx       <= '0;
      r_prev_act   <= 1'b0;
      r_acc        <= '0;
      r_sample_out <= '0;
      r_step_note  <= '0;
      r_sine_phase <= '0;
    end else begin
      if (w_on_hs) begin
        r_step_note <= vb.note_num;
        r_hit       <= w_match || w_free;
        r_sel       <= w_match ? w_match_idx : w_free_idx;
      end
      if ((r_state == S_STEP) && r_hit) begin
        r_step[r_sel]   <= vb.step_val;
        r_phase[r_sel]  <= '0;
        r_note[r_sel]   <= r_step_note;
        r_active[r_sel] <= 1'b1;
      end
      if (w_off_hs) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (w_off_mask[v]) begin
            r_active[v] <= 1'b0;
            r_phase[v]  <= '0;
            r_step[v]   <= '0;
          end
        end
      end
      if (w_start) begin
        r_acc      <= '0;
        r_ridx     <= '0;
        r_prev_act <= 1'b0;
      end
      if (r_state == S_RENDER) begin
        if (w_cur_act) r_phase[r_ridx] <= w_phase_nxt;
        r_sine_phase <= w_sine_phase;
        r_prev_act   <= w_cur_act;
        r_ridx       <= r_ridx + VIDX_W'(1);
      end
      if (w_do_acc) r_acc <= w_acc_sum;
      // Final sum is scaled on the DRAIN edge so sample_out is already valid during EMIT.
      if (r_state == S_DRAIN) r_sample_out <= w_mix;
    end
  end
endmodule

// File: tb/tb_poly_voice_bank.sv
// Directed bench for poly_voice_bank: expected samples go into a scoreboard queue,
// a monitor pops and checks value and arrival cycle on every sample_valid.
module tb_poly_voice_bank;
  localparam int NV = 4;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] sine_const;
  int          cyc;
  int          n_vec;
  int          n_err;
  int          alloc_cnt;
  int          ovr_cnt;
  exp_t        sb_q[$];

  poly_voice_bank_if #(.NUM_VOICES(NV), .PHASE_W(32), .OUT_W(16)) vb ();

  poly_voice_bank #(.NUM_VOICES(NV), .PHASE_W(32), .OUT_W(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vb      (vb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clocked step ROM: 69 -> 0x0100_0000, other notes n -> n << 16.
  always @(posedge clk)
    vb.step_val <= (vb.step_note == 7'd69) ? 32'h0100_0000 : {9'd0, vb.step_note, 16'd0};

  always @(posedge clk) vb.sine_val <= sine_const;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (vb.alloc_drop) alloc_cnt++;
      if (vb.overrun) ovr_cnt++;
      if (vb.sample_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_sample", {16'h0, vb.sample_out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sample_out", {16'h0, vb.sample_out}, {16'h0, e.val});
          chk("sample_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic note(input bit on, input logic [6:0] n);
    int tries;
    tries = 0;
    @(negedge clk);
    vb.note_valid = 1'b1;
    vb.note_on    = on;
    vb.note_num   = n;
    #1;
    while (!vb.note_ready && tries < 40) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!vb.note_ready) chk("note_hs_timeout", 32'd0, 32'd1);
    @(negedge clk);
    vb.note_valid = 1'b0;
    @(negedge clk);
  endtask

  // vchk selects the render slot whose sine_phase is compared (-1: none).
  task automatic samp(input logic [15:0] exp, input int vchk, input logic [15:0] exp_ph);
    @(negedge clk);
    vb.sample_en = 1'b1;
    sb_q.push_back('{exp, cyc + NV + 2});
    @(negedge clk);
    vb.sample_en = 1'b0;
    for (int r = 0; r < NV; r++) begin
      #1;
      if (r == vchk) chk("sine_phase", {16'h0, vb.sine_phase}, {16'h0, exp_ph});
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    int tries;
    int ovr0;
    int alloc0;
    cyc = 0; n_vec = 0; n_err = 0; alloc_cnt = 0; ovr_cnt = 0;
    sine_const    = 16'h4000;
    reset_n       = 1'b0;
    vb.note_valid = 1'b0;
    vb.note_on    = 1'b0;
    vb.note_num   = 7'd0;
    vb.sample_en  = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_sample_valid", {31'd0, vb.sample_valid}, 32'd0);
    chk("rst_sample_out",   {16'h0, vb.sample_out}, 32'd0);
    chk("rst_active_mask",  {28'd0, vb.active_mask}, 32'd0);
    chk("rst_note_ready",   {31'd0, vb.note_ready}, 32'd1);
    chk("rst_sine_phase",   {16'h0, vb.sine_phase}, 32'd0);
    chk("rst_step_note",    {25'd0, vb.step_note}, 32'd0);
    chk("rst_alloc_drop",   {31'd0, vb.alloc_drop}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_note_ready", {31'd0, vb.note_ready}, 32'd1);

    // Single voice: phase steps by 0x0100 per sample, one 0x4000 voice mixes to 0x1000.
    note(1'b1, 7'd69);
    #1 chk("mask_single", {28'd0, vb.active_mask}, 32'h1);
    samp(16'h1000, 0, 16'h0100);
    samp(16'h1000, 0, 16'h0200);
    samp(16'h1000, 0, 16'h0300);
    samp(16'h1000, 0, 16'h0400);

    // Retrigger the same note: same voice, phase restarts.
    note(1'b1, 7'd69);
    #1 chk("mask_retrig1", {28'd0, vb.active_mask}, 32'h1);
    samp(16'h1000, 0, 16'h0100);
    samp(16'h1000, 0, 16'h0200);
    samp(16'h1000, 0, 16'h0300);
    note(1'b1, 7'd69);
    #1 chk("mask_retrig2", {28'd0, vb.active_mask}, 32'h1);
    samp(16'h1000, 0, 16'h0100);

    note(1'b0, 7'd69);
    #1 chk("mask_off69", {28'd0, vb.active_mask}, 32'h0);
    samp(16'h0000, 0, 16'h0000);

    // Full bank, dropped note, free slot reuse.
    note(1'b1, 7'd60);
    note(1'b1, 7'd62);
    note(1'b1, 7'd64);
    note(1'b1, 7'd65);
    #1 chk("mask_full", {28'd0, vb.active_mask}, 32'hF);
    alloc0 = alloc_cnt;
    note(1'b1, 7'd67);
    #1 chk("mask_after_drop", {28'd0, vb.active_mask}, 32'hF);
    chk("alloc_drop_pulse", alloc_cnt, alloc0 + 1);
    note(1'b0, 7'd62);
    #1 chk("mask_off62", {28'd0, vb.active_mask}, 32'hD);
    note(1'b1, 7'd67);
    #1 chk("mask_refill", {28'd0, vb.active_mask}, 32'hF);
    samp(16'h4000, 1, 16'h0043);
    samp(16'h4000, 3, 16'h0082);

    // Mix sign and scaling.
    sine_const = 16'h8000;
    samp(16'h8000, -1, 16'h0000);
    sine_const = 16'h7FFF;
    samp(16'h7FFF, -1, 16'h0000);
    note(1'b0, 7'd60);
    #1 chk("mask_off60", {28'd0, vb.active_mask}, 32'hE);
    sine_const = 16'h8000;
    samp(16'hA000, 0, 16'h0000);

    // Note and sample strobe together: the sample wins, the note waits for IDLE.
    @(negedge clk);
    vb.note_valid = 1'b1;
    vb.note_on    = 1'b1;
    vb.note_num   = 7'd70;
    vb.sample_en  = 1'b1;
    t    = cyc;
    ovr0 = ovr_cnt;
    sb_q.push_back('{16'hA000, t + NV + 2});
    #1 chk("collide_note_ready", {31'd0, vb.note_ready}, 32'd0);
    @(negedge clk);
    vb.sample_en = 1'b0;
    @(negedge clk);
    vb.sample_en = 1'b1;
    @(negedge clk);
    vb.sample_en = 1'b0;
    tries = 0;
    #1;
    while (!vb.note_ready && tries < 40) begin
      @(negedge clk);
      #1;
      tries++;
    end
    chk("collide_accept_cyc", cyc, t + NV + 3);
    chk("overrun_pulse", ovr_cnt, ovr0 + 1);
    @(negedge clk);
    vb.note_valid = 1'b0;
    @(negedge clk);
    #1 chk("mask_collide", {28'd0, vb.active_mask}, 32'hF);
    samp(16'h8000, 0, 16'h0046);

    // Asynchronous reset in the middle of a render.
    @(negedge clk);
    vb.sample_en = 1'b1;
    @(negedge clk);
    vb.sample_en = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_sample_valid", {31'd0, vb.sample_valid}, 32'd0);
    chk("midrst_active_mask",  {28'd0, vb.active_mask}, 32'd0);
    chk("midrst_note_ready",   {31'd0, vb.note_ready}, 32'd1);
    chk("midrst_sine_phase",   {16'h0, vb.sine_phase}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk("midrst_release_ready", {31'd0, vb.note_ready}, 32'd1);
    samp(16'h0000, 0, 16'h0000);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("alloc_drop_total", alloc_cnt, 32'd1);
    chk("overrun_total", ovr_cnt, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
